// File: rtl/piso_stream.sv
// piso_stream: takes a WIDTH-bit word over valid/ready and sends it out one bit per accepted serial beat.
// Latency: the first bit appears 1 cycle after the load edge. Consecutive words run with no idle cycle.
// Backpressure: out_ready=0 freezes the shifter. in_ready is high only when idle, or on the last bit while out_ready=1.
// Ports: clk, rst (synchronous, active-high)
//        in_valid / in_ready / in_data       parallel word side
//        out_bit / out_valid / out_ready     serial side, plus out_last on the final bit of a word
//        busy                                a word is in flight (same as out_valid)
// WIDTH must be >= 2.
module piso_stream #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sreg;
  // Number of bits still to send after the one currently on out_bit.
  logic [CW-1:0]    r_cnt;

  logic             w_shifting;
  logic             w_on_last;
  logic             w_load;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sreg_next;

  assign w_shifting = (r_state == SHIFT);
  assign w_on_last  = (r_cnt == '0);

  // A new word can be taken on the same edge that retires the last bit of the previous one.
  // That is what removes the idle cycle between back-to-back words.
  assign in_ready = !w_shifting || (w_on_last && out_ready);
  assign w_load   = in_valid && in_ready;
  assign w_xfer   = w_shifting && out_ready;

  // The output end of the register is fixed by MSB_FIRST.
  // Data always moves toward that end, and zeros fill in from the other side.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sreg_next = {r_sreg[WIDTH-2:0], 1'b0};
      assign out_bit     = r_sreg[WIDTH-1];
    end else begin : g_lsb_first
      assign w_sreg_next = {1'b0, r_sreg[WIDTH-1:1]};
      assign out_bit     = r_sreg[0];
    end
  endgenerate

  assign out_valid = w_shifting;
  assign busy      = w_shifting;
  assign out_last  = w_shifting && w_on_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      // This covers a load from IDLE and a reload on the last accepted bit.
      r_state <= SHIFT;
      r_sreg  <= in_data;
      r_cnt   <= LAST_IDX;
    end else if (w_xfer) begin
      if (!w_on_last) begin
        r_sreg <= w_sreg_next;
        r_cnt  <= r_cnt - CW'(1);
      end else begin
        r_state <= IDLE;
      end
    end
  end

endmodule
